spypath_meter: RTL and testbench

//  Launch/capture end of a spy delay path. Drives transitions into the path input and samples
//  the path result through a synchronizer. Counts clock cycles from launch to arrival and

---
 rtl/spypath_meter_pkg.sv | 18 +
 rtl/spypath_sync2.sv | 20 ++
 rtl/spypath_meter.sv | 161 ++++++++++++++++
 tb/tb_spypath_meter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spypath_meter_pkg.sv
// Shared types and helpers for the spy-path delay meter.
package spypath_meter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_MEASURE,
    S_FINISH
  } state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int sum_width(input int cnt_w, input int trials_log2);
    return cnt_w + trials_log2;
  endfunction

endpackage

// File: rtl/spypath_sync2.sv
// Two-flop synchronizer for the asynchronous spy-path result; flops kept so they are never merged away.
module spypath_sync2
  import spypath_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  (* keep = "true" *) logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stages <= '0;
    else     stages <= {stages[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spypath_meter.sv
// Launch/capture timer for a spy delay path: averages 2**TRIALS_LOG2 launch-to-arrival cycle counts.
// Define SPY_MINMAX_EN to add per-measurement minOut/maxOut of the trial counts.
module spypath_meter
  import spypath_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TRIALS_LOG2 = 4,
  parameter int TIMEOUT     = 1023,
  parameter int SETTLE      = 8,
  parameter int PATH_INV    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         pathInput,
  input  logic                         pathResult,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [CNT_W+TRIALS_LOG2-1:0] sumOut,
`ifdef SPY_MINMAX_EN
  output logic [CNT_W-1:0]             avgOut,
  output logic [CNT_W-1:0]             minOut,
  output logic [CNT_W-1:0]             maxOut
`else
  output logic [CNT_W-1:0]             avgOut
`endif
);

  localparam int   SUM_W   = sum_width(CNT_W, TRIALS_LOG2);
  localparam logic INV_BIT = (PATH_INV != 0);

  state_t                 state, state_next;
  logic                   res_s;
  logic [CNT_W-1:0]       cnt, cnt_inc, stable;
  logic [TRIALS_LOG2-1:0] trial;
  logic [SUM_W-1:0]       sum, sum_next;
  logic                   match, expire, arrive, finishing;

  spypath_sync2 u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pathResult),
    .sync_out (res_s)
  );

  assign cnt_inc   = cnt + CNT_W'(1);
  assign match     = (res_s == (pathInput ^ INV_BIT));
  assign expire    = (cnt_inc == CNT_W'(TIMEOUT));
  assign arrive    = (state == S_MEASURE) && match;
  assign finishing = (state_next == S_FINISH);
  // The last trial's count must already be in the sum when outputs latch on entry to FINISH.
  assign sum_next  = arrive ? sum + SUM_W'(cnt_inc) : sum;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_SETTLE;
      S_SETTLE: begin
        if (match && stable == CNT_W'(SETTLE - 1)) state_next = S_LAUNCH;
        else if (expire)                           state_next = S_FINISH;
      end
      S_LAUNCH:  state_next = S_MEASURE;
      S_MEASURE: begin
        if (match)       state_next = (trial == '1) ? S_FINISH : S_SETTLE;
        else if (expire) state_next = S_FINISH;
      end
      S_FINISH:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pathInput <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      sumOut    <= '0;
      avgOut    <= '0;
      cnt       <= '0;
      stable    <= '0;
      trial     <= '0;
      sum       <= '0;
    end else begin
      state <= state_next;
      done  <= finishing;
      sum   <= sum_next;
      case (state)
        S_IDLE: if (start) begin
          busy    <= 1'b1;
          timeout <= 1'b0;
          sum     <= '0;
          trial   <= '0;
          cnt     <= '0;
          stable  <= '0;
        end
        S_SETTLE: begin
          cnt    <= cnt_inc;
          stable <= match ? stable + CNT_W'(1) : '0;
          // Toggling here makes the launch edge the one that enters LAUNCH, so counts start from it.
          if (state_next == S_LAUNCH) pathInput <= ~pathInput;
          if (finishing)              timeout   <= 1'b1;
        end
        S_LAUNCH:  cnt <= '0;
        S_MEASURE: begin
          cnt <= cnt_inc;
          if (match) begin
            trial  <= trial + TRIALS_LOG2'(1);
            cnt    <= '0;
            stable <= '0;
          end else if (expire) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
      if (finishing) begin
        busy   <= 1'b0;
        sumOut <= sum_next;
        avgOut <= sum_next[SUM_W-1:TRIALS_LOG2];
      end
    end
  end

`ifdef SPY_MINMAX_EN
  logic [CNT_W-1:0] trial_min, trial_max, min_next, max_next;

  always_comb begin
    min_next = trial_min;
    max_next = trial_max;
    if (arrive) begin
      if (cnt_inc < trial_min) min_next = cnt_inc;
      if (cnt_inc > trial_max) max_next = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trial_min <= '0;
      trial_max <= '0;
      minOut    <= '0;
      maxOut    <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        trial_min <= '1;
        trial_max <= '0;
      end else begin
        trial_min <= min_next;
        trial_max <= max_next;
      end
      if (finishing) begin
        minOut <= min_next;
        maxOut <= max_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spypath_meter.sv
// Directed self-checking bench for spypath_meter; the path is modelled as a D-cycle delay line.
// Build with SPY_MINMAX_EN defined to also exercise minOut/maxOut.
module tb_spypath_meter;

  localparam int CNT_W       = 16;
  localparam int TRIALS_LOG2 = 4;
  localparam int SUM_W       = CNT_W + TRIALS_LOG2;
  localparam int SETTLE      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_inv = 1'b0;

  logic             path_in, path_res, busy, done, timeout;
  logic [SUM_W-1:0] sum_out;
  logic [CNT_W-1:0] avg_out;
  logic             path_in_inv, path_res_inv, busy_inv, done_inv, timeout_inv;
  logic [SUM_W-1:0] sum_inv;
  logic [CNT_W-1:0] avg_inv;
`ifdef SPY_MINMAX_EN
  logic [CNT_W-1:0] min_out, max_out, min_inv, max_inv;
`endif

  logic [15:0] dl, dl_inv;
  logic [3:0]  tap;
  int          d_fixed = 5;
  bit          alt_mode = 1'b0;
  bit          stuck = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  spypath_meter #(.PATH_INV(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pathInput(path_in), .pathResult(path_res),
    .busy(busy), .done(done), .timeout(timeout),
    .sumOut(sum_out),
`ifdef SPY_MINMAX_EN
    .avgOut(avg_out), .minOut(min_out), .maxOut(max_out)
`else
    .avgOut(avg_out)
`endif
  );

  spypath_meter #(.PATH_INV(1)) dut_inv (
    .clk(clk), .rst(rst), .start(start_inv),
    .pathInput(path_in_inv), .pathResult(path_res_inv),
    .busy(busy_inv), .done(done_inv), .timeout(timeout_inv),
    .sumOut(sum_inv),
`ifdef SPY_MINMAX_EN
    .avgOut(avg_inv), .minOut(min_inv), .maxOut(max_inv)
`else
    .avgOut(avg_inv)
`endif
  );

  // Delay-line path models: tap D-1 gives a D-cycle delay; alt_mode uses 4 cycles for rises, 9 for falls.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dl     <= '0;
      dl_inv <= '0;
    end else begin
      dl     <= {dl[14:0], path_in};
      dl_inv <= {dl_inv[14:0], path_in_inv};
    end
  end

  always_comb begin
    tap      = alt_mode ? (path_in ? 4'd3 : 4'd8) : 4'(d_fixed - 1);
    path_res = stuck ? 1'b0 : dl[tap];
  end

  assign path_res_inv = ~dl_inv[2];

  task automatic run_meas(output bit got_done, output int cycles, output logic busy_early);
    got_done   = 1'b0;
    busy_early = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    cycles = 1;
    while (cycles < 5000) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (cycles == 2) busy_early = busy;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (path_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_path: got %b expected 0", path_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (sum_out !== '0) begin errors++; $display("[TB] FAIL reset_sum: got %0d expected 0", sum_out); end
    checks++; if (avg_out !== '0) begin errors++; $display("[TB] FAIL reset_avg: got %0d expected 0", avg_out); end
    checks++; if (path_in_inv !== 1'b0) begin errors++; $display("[TB] FAIL reset_path_inv: got %b expected 0", path_in_inv); end
`ifdef SPY_MINMAX_EN
    checks++; if (min_out !== '0 || max_out !== '0) begin errors++; $display("[TB] FAIL reset_minmax: got %0d/%0d expected 0/0", min_out, max_out); end
`endif
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic();
    bit got; int cyc; logic b;
    d_fixed = 5;
    run_meas(got, cyc, b);
    checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %b expected 1 after %0d cycles", got, cyc); end
    checks++; if (b !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_rise: got %b expected 1", b); end
    checks++; if (sum_out !== 20'd112) begin errors++; $display("[TB] FAIL basic_sum: got %0d expected 112", sum_out); end
    checks++; if (avg_out !== 16'd7) begin errors++; $display("[TB] FAIL basic_avg: got %0d expected 7", avg_out); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: got %b expected 0", timeout); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || path_in !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got busy %b path %b expected 0 0", busy, path_in); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_inverting();
    int toggles = 0;
    int cyc = 0;
    bit got = 1'b0;
    logic last;
    @(negedge clk);
    start_inv = 1'b1;
    last = path_in_inv;
    while (cyc < 5000) begin
      @(negedge clk);
      start_inv = 1'b0;
      cyc++;
      if (path_in_inv !== last) begin
        toggles++;
        last = path_in_inv;
      end
      if (done_inv) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL inv_done: got %b expected 1", got); end
    checks++; if (avg_inv !== 16'd5) begin errors++; $display("[TB] FAIL inv_avg: got %0d expected 5", avg_inv); end
    checks++; if (sum_inv !== 20'd80) begin errors++; $display("[TB] FAIL inv_sum: got %0d expected 80", sum_inv); end
    checks++; if (toggles != 16) begin errors++; $display("[TB] FAIL inv_toggles: got %0d expected 16", toggles); end
    checks++; if (path_in_inv !== 1'b0) begin errors++; $display("[TB] FAIL inv_final_path: got %b expected 0", path_in_inv); end
    checks++; if (timeout_inv !== 1'b0) begin errors++; $display("[TB] FAIL inv_timeout: got %b expected 0", timeout_inv); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit got; int cyc; logic b;
    stuck = 1'b1;
    run_meas(got, cyc, b);
    checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL to_done: got %b expected 1", got); end
    checks++; if (cyc != 1025 + SETTLE + 1) begin errors++; $display("[TB] FAIL to_latency: got %0d expected %0d", cyc, 1025 + SETTLE + 1); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_flag: got %b expected 1", timeout); end
    checks++; if (sum_out !== '0) begin errors++; $display("[TB] FAIL to_sum: got %0d expected 0", sum_out); end
    stuck = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int dones = 0;
    int tail_busy = 0;
    int tail = 0;
    d_fixed = 5;
    @(negedge clk);
    start = 1'b1;
    while (cyc < 5000 && dones == 0) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 20);
      if (done) begin
        dones++;
        start = 1'b1;
      end
    end
    while (tail < 300) begin
      @(negedge clk);
      start = 1'b0;
      tail++;
      if (done) dones++;
      if (busy) tail_busy++;
    end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL b2b_dones: got %0d expected 1", dones); end
    checks++; if (tail_busy != 0) begin errors++; $display("[TB] FAIL b2b_restart: got %0d busy cycles expected 0", tail_busy); end
    checks++; if (sum_out !== 20'd112) begin errors++; $display("[TB] FAIL b2b_sum: got %0d expected 112", sum_out); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL b2b_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_reset_abort();
    bit got; int cyc; logic b;
    int toggles = 0;
    int n = 0;
    logic last;
    @(negedge clk);
    start = 1'b1;
    last = path_in;
    while (n < 3000 && toggles < 7) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (path_in !== last) begin
        toggles++;
        last = path_in;
      end
    end
    checks++; if (toggles != 7) begin errors++; $display("[TB] FAIL abort_reach_trial7: got %0d launches expected 7", toggles); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (path_in !== 1'b0) begin errors++; $display("[TB] FAIL abort_path: got %b expected 0", path_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (sum_out !== '0) begin errors++; $display("[TB] FAIL abort_sum: got %0d expected 0", sum_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run_meas(got, cyc, b);
    checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL abort_rerun_done: got %b expected 1", got); end
    checks++; if (sum_out !== 20'd112) begin errors++; $display("[TB] FAIL abort_rerun_sum: got %0d expected 112", sum_out); end
    checks++; if (avg_out !== 16'd7) begin errors++; $display("[TB] FAIL abort_rerun_avg: got %0d expected 7", avg_out); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL abort_rerun_timeout: got %b expected 0", timeout); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_minmax();
    bit got; int cyc; logic b;
    alt_mode = 1'b1;
    run_meas(got, cyc, b);
    checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL mm_done: got %b expected 1", got); end
    checks++; if (sum_out !== 20'd136) begin errors++; $display("[TB] FAIL mm_sum: got %0d expected 136", sum_out); end
    checks++; if (avg_out !== 16'd8) begin errors++; $display("[TB] FAIL mm_avg: got %0d expected 8", avg_out); end
`ifdef SPY_MINMAX_EN
    checks++; if (min_out !== 16'd6) begin errors++; $display("[TB] FAIL mm_min: got %0d expected 6", min_out); end
    checks++; if (max_out !== 16'd11) begin errors++; $display("[TB] FAIL mm_max: got %0d expected 11", max_out); end
`endif
    alt_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverting();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    test_minmax();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
